// File: rtl/afpm_pkg.sv
// Shared types and sizing for the AFPM operand deserializer.
package afpm_pkg;

   localparam int OP_WIDTH = 16;
   localparam int BYTE_W   = 8;
   localparam int NB       = OP_WIDTH / BYTE_W;
   localparam int IDXW     = (NB > 1) ? $clog2(NB) : 1;
   localparam int TIMER_W  = 8;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/afpm_idle_timer.sv
// Load/clear/enable down-counter; expire pulses on the last enabled count.
module afpm_idle_timer
   import afpm_pkg::*;
#(
   parameter int unsigned LOAD_VAL = 15
)(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic clear,
   input  logic en,
   output logic expire
);

   logic [TIMER_W-1:0] cnt;

   assign expire = en & (cnt == TIMER_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= TIMER_W'(LOAD_VAL);
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/afpm_operand_deserializer.sv
// Assembles A/B operands from byte pairs, LSB first, and hands them
// to the multiplier core as one valid/ready transfer.
module afpm_operand_deserializer
   import afpm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 15
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                byte_valid,
   input  logic [BYTE_W-1:0]   byte_a,
   input  logic [BYTE_W-1:0]   byte_b,
   input  logic                core_ready,
   input  logic                clear_err,
   output logic [OP_WIDTH-1:0] op_a,
   output logic [OP_WIDTH-1:0] op_b,
   output logic                op_valid,
   output logic                busy,
   output logic                err_overrun,
   output logic                err_timeout
);

   state_t          state;
   logic [IDXW-1:0] k;
   logic [IDXW-1:0] idx;
   logic            accept;
   logic            xfer;
   logic            overrun;
   logic            idle_en;
   logic            tick;

   // A byte landing on the transfer cycle starts the next frame at index 0.
   assign xfer    = (state == HOLD) & core_ready;
   assign accept  = ena & byte_valid & ((state == COLLECT) | core_ready);
   assign overrun = ena & byte_valid & (state == HOLD) & ~core_ready;
   assign idx     = (state == HOLD) ? '0 : k;
   assign idle_en = ena & (state == COLLECT) & (k != '0) & ~byte_valid;
   assign busy    = (k != '0);

   afpm_idle_timer #(
      .LOAD_VAL (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .clear  (~ena),
      .en     (idle_en),
      .expire (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= COLLECT;
         k           <= '0;
         op_a        <= '0;
         op_b        <= '0;
         op_valid    <= 1'b0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (!ena) begin
            state    <= COLLECT;
            k        <= '0;
            op_valid <= 1'b0;
         end else if (accept) begin
            for (int i = 0; i < NB; i++) begin
               if (idx == IDXW'(i)) begin
                  op_a[i*BYTE_W +: BYTE_W] <= byte_a;
                  op_b[i*BYTE_W +: BYTE_W] <= byte_b;
               end
            end
            if (idx == LAST_IDX) begin
               state    <= HOLD;
               op_valid <= 1'b1;
               k        <= '0;
            end else begin
               state    <= COLLECT;
               op_valid <= 1'b0;
               k        <= idx + 1'b1;
            end
         end else if (xfer) begin
            state    <= COLLECT;
            op_valid <= 1'b0;
         end else if (tick) begin
            k <= '0;
         end

         if (overrun) begin
            err_overrun <= 1'b1;
         end else if (clear_err) begin
            err_overrun <= 1'b0;
         end

         if (tick) begin
            err_timeout <= 1'b1;
         end else if (clear_err) begin
            err_timeout <= 1'b0;
         end
      end
   end

endmodule
